// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared types and default sizing for the data_memory_sync block.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int DMEM_WIDTH_DEF = 8;
    localparam int DMEM_DEPTH_DEF = 16;

    typedef enum logic [0:0] {
        DMEM_CLEAR = 1'b0,
        DMEM_READY = 1'b1
    } dmem_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : dmem_clear_seq
// Brief    : Zero-sweep sequencer; owns the memory state, clear pointer and busy.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_clear_seq
    import dmem_pkg::*;
#(
    parameter  int DEPTH  = DMEM_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic              o_zero_en,
    output logic [ADDR_W-1:0] o_zero_addr,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);

    dmem_state_t       r_state;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic              r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DMEM_CLEAR;
            r_clr_ptr <= '0;
            r_busy    <= 1'b1;
        end else begin
            case (r_state)
                DMEM_CLEAR: begin
                    // A clear request mid-sweep restarts it from word 0.
                    if (i_clear) begin
                        r_clr_ptr <= '0;
                    end else if (r_clr_ptr == c_last_ptr) begin
                        r_state   <= DMEM_READY;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b0;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + 1'b1;
                    end
                end
                DMEM_READY: begin
                    if (i_clear) begin
                        r_state   <= DMEM_CLEAR;
                        r_clr_ptr <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= DMEM_CLEAR;
                    r_clr_ptr <= '0;
                    r_busy    <= 1'b1;
                end
            endcase
        end
    end

    assign o_zero_en   = (r_state == DMEM_CLEAR);
    assign o_zero_addr = r_clr_ptr;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: rtl/data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_sync
// Brief    : Clocked data memory with registered read and hardware zero-sweep.
//            Define DMEM_BYPASS_EN for write-first same-address forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_sync
    import dmem_pkg::*;
#(
    parameter  int WIDTH  = DMEM_WIDTH_DEF,
    parameter  int DEPTH  = DMEM_DEPTH_DEF,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;

    logic              w_zero_en;
    logic [ADDR_W-1:0] w_zero_addr;
    logic              w_busy;
    logic              w_wr_in_range;
    logic              w_rd_in_range;
    logic              w_wr_accept;
    logic              w_rd_accept;
    logic [WIDTH-1:0]  w_rd_word;

    dmem_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (clear),
        .o_zero_en   (w_zero_en),
        .o_zero_addr (w_zero_addr),
        .o_busy      (w_busy)
    );

    assign w_wr_in_range = ({1'b0, wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, rd_addr} < c_depth);
    // clear beats a same-cycle write; reads in that cycle still see old data.
    assign w_wr_accept   = wr_en && !w_busy && !clear && w_wr_in_range;
    assign w_rd_accept   = rd_en && !w_busy;

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[rd_addr];
`ifdef DMEM_BYPASS_EN
            if (w_wr_accept && (wr_addr == rd_addr)) begin
                w_rd_word = wr_data;
            end
`endif
        end
    end

    // Sweep writes take the port ahead of user writes; the two never overlap.
    always_ff @(posedge clk) begin
        if (w_zero_en) begin
            r_mem[w_zero_addr] <= '0;
        end else if (w_wr_accept) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_accept;
            if (w_rd_accept) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_data_memory_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_sync
// Brief    : Self-checking bench for data_memory_sync (DEPTH=16 and DEPTH=10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_sync;

`ifdef DMEM_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    logic       clk = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;

    // DEPTH=16 instance
    logic       rst = 1'b1, clear = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
    logic [3:0] wr_addr = '0, rd_addr = '0;
    logic [7:0] wr_data = '0, rd_data;
    logic       rd_valid, busy;

    // DEPTH=10 instance
    logic       rst_b = 1'b1, clear_b = 1'b0, wr_en_b = 1'b0, rd_en_b = 1'b0;
    logic [3:0] wr_addr_b = '0, rd_addr_b = '0;
    logic [7:0] wr_data_b = '0, rd_data_b;
    logic       rd_valid_b, busy_b;

    always #5 clk = ~clk;

    data_memory_sync #(.WIDTH(8), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy)
    );

    data_memory_sync #(.WIDTH(8), .DEPTH(10)) dut10 (
        .clk(clk), .rst(rst_b), .clear(clear_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .busy(busy_b)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: busy=%b rd_valid=%b rd_data=%h, required 1 0 00", busy, rd_valid, rd_data);
        end
        rst = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL reset_sweep_len: got %0d cycles, required 16", cnt);
        end
        for (int i = 0; i < 16; i++) begin
            rd_en = 1'b1; rd_addr = 4'(i);
            step();
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_read[%0d]: valid=%b data=%h, required 1 00", i, rd_valid, rd_data);
            end
        end
        rd_en = 1'b0;
    endtask

    task automatic test_write_read();
        logic [3:0] a [3] = '{4'd0, 4'd7, 4'd15};
        logic [7:0] d [3] = '{8'hAA, 8'h55, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = a[i]; wr_data = d[i];
            step();
        end
        wr_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rd_en = 1'b1; rd_addr = a[i];
            step();
            rd_en = 1'b0;
            n_cmp++;
            if (rd_valid !== 1'b1 || rd_data !== d[i]) begin
                n_bad++;
                $display("FAIL write_read[%0d]: valid=%b data=%h, required 1 %h", a[i], rd_valid, rd_data, d[i]);
            end
            step();
            n_cmp++;
            if (rd_valid !== 1'b0 || rd_data !== d[i]) begin
                n_bad++;
                $display("FAIL read_pulse_hold[%0d]: valid=%b data=%h, required 0 %h", a[i], rd_valid, rd_data, d[i]);
            end
        end
    endtask

    task automatic test_busy_block();
        int cnt;
        int bad_valid;
        clear = 1'b1; rd_en = 1'b1; rd_addr = 4'd0;
        step();
        clear = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hAA || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_on_clear: valid=%b data=%h busy=%b, required 1 aa 1", rd_valid, rd_data, busy);
        end
        rd_en = 1'b1; rd_addr = 4'd3;
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 8'hCC;
        cnt = 0; bad_valid = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
            if (rd_valid !== 1'b0) bad_valid++;
        end
        wr_en = 1'b0; rd_en = 1'b0;
        n_cmp++;
        if (bad_valid != 0 || cnt != 16) begin
            n_bad++;
            $display("FAIL busy_block: %0d valid pulses over %0d cycles, required 0 over 16", bad_valid, cnt);
        end
        rd_en = 1'b1; rd_addr = 4'd3;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL busy_write_dropped: valid=%b data=%h, required 1 00", rd_valid, rd_data);
        end
    endtask

    task automatic test_clear_priority();
        int cnt;
        wr_en = 1'b1; wr_addr = 4'd9; wr_data = 8'h11;
        step();
        clear = 1'b1; wr_data = 8'h99;
        step();
        clear = 1'b0; wr_en = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != 16) begin
            n_bad++;
            $display("FAIL clear_prio_sweep_len: got %0d cycles, required 16", cnt);
        end
        rd_en = 1'b1; rd_addr = 4'd9;
        step();
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL clear_prio_read: valid=%b data=%h, required 1 00", rd_valid, rd_data);
        end
    endtask

    task automatic test_same_addr();
        logic [7:0] exp_first;
        exp_first = c_bypass ? 8'hBE : 8'hDE;
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'hDE;
        step();
        wr_data = 8'hBE; rd_en = 1'b1; rd_addr = 4'd5;
        step();
        wr_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== exp_first) begin
            n_bad++;
            $display("FAIL same_addr_rw: valid=%b data=%h, required 1 %h", rd_valid, rd_data, exp_first);
        end
        step();
        rd_en = 1'b0;
        n_cmp++;
        if (rd_valid !== 1'b1 || rd_data !== 8'hBE) begin
            n_bad++;
            $display("FAIL same_addr_next: valid=%b data=%h, required 1 be", rd_valid, rd_data);
        end
    endtask

    // Reference model: memory array plus a count of sweep cycles still owed.
    task automatic test_random();
        logic [7:0] ref_mem [16];
        int         remaining;
        logic [7:0] exp_data;
        logic       exp_valid;
        logic       data_known;
        remaining  = 0;
        data_known = 1'b0;
        exp_data   = '0;
        foreach (ref_mem[k]) ref_mem[k] = '0;
        for (int i = 0; i < 400; i++) begin
            clear   = (i == 0) || ($urandom_range(0, 39) == 0);
            wr_en   = 1'($urandom_range(0, 1));
            rd_en   = (i != 0) && ($urandom_range(0, 2) != 0);
            wr_addr = 4'($urandom_range(0, 15));
            rd_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 4'($urandom_range(0, 15));
            wr_data = 8'($urandom);
            exp_valid = 1'b0;
            if (remaining > 0) begin
                if (clear) remaining = 16;
                else remaining--;
            end else begin
                if (rd_en) begin
                    exp_valid  = 1'b1;
                    data_known = 1'b1;
                    if (c_bypass && wr_en && !clear && wr_addr == rd_addr) exp_data = wr_data;
                    else exp_data = ref_mem[rd_addr];
                end
                if (clear) begin
                    remaining = 16;
                    foreach (ref_mem[k]) ref_mem[k] = '0;
                end else if (wr_en) begin
                    ref_mem[wr_addr] = wr_data;
                end
            end
            step();
            n_cmp++;
            if (busy !== (remaining > 0) || rd_valid !== exp_valid) begin
                n_bad++;
                $display("FAIL random_ctrl cyc %0d: busy=%b valid=%b, required %b %b", i, busy, rd_valid, (remaining > 0), exp_valid);
            end
            if (data_known) begin
                n_cmp++;
                if (rd_data !== exp_data) begin
                    n_bad++;
                    $display("FAIL random_data cyc %0d: rd_data=%h, required %h", i, rd_data, exp_data);
                end
            end
        end
        clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    endtask

    task automatic test_odd_depth();
        int cnt;
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        repeat (4) step();
        rst_b = 1'b1;
        #1;
        n_cmp++;
        if (busy_b !== 1'b1 || rd_valid_b !== 1'b0) begin
            n_bad++;
            $display("FAIL odd_midsweep_rst: busy=%b valid=%b, required 1 0", busy_b, rd_valid_b);
        end
        step();
        rst_b = 1'b0;
        cnt = 0;
        while (busy_b === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt != 10) begin
            n_bad++;
            $display("FAIL odd_sweep_len: got %0d cycles, required 10", cnt);
        end
        wr_en_b = 1'b1; wr_addr_b = 4'd9; wr_data_b = 8'h5A;
        step();
        wr_addr_b = 4'd12; wr_data_b = 8'h77; rd_en_b = 1'b1; rd_addr_b = 4'd9;
        step();
        wr_en_b = 1'b0;
        n_cmp++;
        if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h5A) begin
            n_bad++;
            $display("FAIL odd_read9: valid=%b data=%h, required 1 5a", rd_valid_b, rd_data_b);
        end
        rd_addr_b = 4'd12;
        step();
        n_cmp++;
        if (rd_valid_b !== 1'b1 || rd_data_b !== 8'h00) begin
            n_bad++;
            $display("FAIL odd_read12: valid=%b data=%h, required 1 00", rd_valid_b, rd_data_b);
        end
        for (int i = 0; i < 10; i++) begin
            rd_addr_b = 4'(i);
            step();
            n_cmp++;
            if (rd_valid_b !== 1'b1 || rd_data_b !== ((i == 9) ? 8'h5A : 8'h00)) begin
                n_bad++;
                $display("FAIL odd_readback[%0d]: valid=%b data=%h, required 1 %h", i, rd_valid_b, rd_data_b, ((i == 9) ? 8'h5A : 8'h00));
            end
        end
        rd_en_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_busy_block();
        test_clear_priority();
        test_same_addr();
        test_random();
        test_odd_depth();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
